// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - multi-channel synchroniser, debounce, edge pulse, pending flags, event counter
module multi_edge_detector #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CHANNELS-1:0]  signal,
   input  logic [1:0]           mode,
   input  logic [CHANNELS-1:0]  clear,
   input  logic                 count_clr,
   output logic [CHANNELS-1:0]  outedge,
   output logic [CHANNELS-1:0]  stable,
   output logic [CHANNELS-1:0]  pending,
   output logic [CNT_WIDTH-1:0] event_count
);

   // A debounce length of 0 behaves as 1: the first mismatched cycle flips stable.
   localparam int DB_LEN = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam int DB_W   = $clog2(DB_LEN + 1);
   localparam int SS     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int PC_W   = $clog2(CHANNELS + 1);
   localparam int SUM_W  = CNT_WIDTH + PC_W;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [DB_W-1:0]      DB_LAST  = DB_W'(DB_LEN - 1);

   logic [CHANNELS-1:0][SS-1:0]   sync_chain;
   logic [CHANNELS-1:0]           sync;
   logic [CHANNELS-1:0][DB_W-1:0] db_cnt;
   logic [CHANNELS-1:0]           prev;
   logic [CHANNELS-1:0]           rise;
   logic [CHANNELS-1:0]           fall;
   logic [CHANNELS-1:0]           edge_next;
   logic [PC_W-1:0]               edge_pop;
   logic [CNT_WIDTH-1:0]          count_base;
   logic [SUM_W-1:0]              count_sum;
   logic [CNT_WIDTH-1:0]          count_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_chain <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_chain[i] <= {sync_chain[i][SS-2:0], signal[i]};
         end
      end
   end

   always_comb begin
      sync = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sync[i] = sync_chain[i][SS-1];
      end
   end

   // Any cycle where the synchronised level agrees with stable restarts the count,
   // so only an unbroken run of DB_LEN mismatches can flip the level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= '0;
         db_cnt <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= ~stable[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rise      = stable & ~prev;
      fall      = ~stable & prev;
      edge_next = '0;
      case (mode)
         2'b00:   edge_next = rise;
         2'b01:   edge_next = fall;
         2'b10:   edge_next = rise | fall;
         default: edge_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev    <= '0;
         outedge <= '0;
         pending <= '0;
      end else begin
         prev    <= stable;
         outedge <= edge_next;
         pending <= (pending & ~clear) | outedge;
      end
   end

   always_comb begin
      edge_pop = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         edge_pop = edge_pop + PC_W'(outedge[i]);
      end
   end

   // Clear is applied before this cycle's edges are added, then the sum saturates.
   always_comb begin
      count_base = count_clr ? '0 : event_count;
      count_sum  = SUM_W'(count_base) + SUM_W'(edge_pop);
      if (count_sum > SUM_W'(CNT_MAX)) begin
         count_next = CNT_MAX;
      end else begin
         count_next = count_sum[CNT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_count <= '0;
      end else begin
         event_count <= count_next;
      end
   end

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - directed bench for multi_edge_detector
module tb_multi_edge_detector;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] signal, clear, outedge, stable, pending;
   logic [1:0] mode;
   logic       count_clr;
   logic [7:0] event_count;

   logic [3:0] sig_s, clr_s, out_s, st_s, pend_s;
   logic [1:0] mode_s;
   logic       cclr_s;
   logic [2:0] cnt_s;

   always #5 clk = ~clk;

   multi_edge_detector dut (
      .clk(clk), .reset(reset), .signal(signal), .mode(mode), .clear(clear),
      .count_clr(count_clr), .outedge(outedge), .stable(stable),
      .pending(pending), .event_count(event_count)
   );

   multi_edge_detector #(.CNT_WIDTH(3)) dut_s (
      .clk(clk), .reset(reset), .signal(sig_s), .mode(mode_s), .clear(clr_s),
      .count_clr(cclr_s), .outedge(out_s), .stable(st_s),
      .pending(pend_s), .event_count(cnt_s)
   );

   typedef struct {
      logic [3:0] sig;
      logic [3:0] clr;
      logic [3:0] e_out;
      logic [3:0] e_st;
      logic [3:0] e_pend;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] s, input logic [3:0] c, input logic [3:0] eo,
                      input logic [3:0] est, input logic [3:0] ep, input logic [7:0] ec);
      vec_t v;
      v.sig = s; v.clr = c; v.e_out = eo; v.e_st = est; v.e_pend = ep; v.e_cnt = ec;
      vecs.push_back(v);
   endtask

   task automatic run_phase(input int n, input int ch, output int pulses, output int maxrun);
      int run;
      run = 0; pulses = 0; maxrun = 0;
      for (int c = 0; c < n; c++) begin
         tick();
         if (outedge[ch]) begin
            if (run == 0) pulses++;
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] modes [3];
      int         exp_a [3];
      int         exp_b [3];
      int         a, b, ra, rb, base, first_idx, pulses, found;

      reset = 1'b1; signal = '0; mode = 2'b00; clear = '0; count_clr = 1'b0;
      sig_s = '0; mode_s = 2'b00; clr_s = '0; cclr_s = 1'b0;
      repeat (3) tick();
      check("rst_outedge", 32'(outedge), 0);
      check("rst_stable", 32'(stable), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_count", 32'(event_count), 0);
      check("rst_count_s", 32'(cnt_s), 0);
      reset = 1'b0;
      repeat (2) tick();

      // rising edge on ch0, pending set/clear collision, 3-cycle glitch on ch1
      for (int n = 0; n < 5; n++) add(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
      add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd0);
      add(4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 8'd0);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 8'd1);
      add(4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 8'd1);
      add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd1);
      for (int n = 0; n < 3; n++) add(4'b0011, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd1);
      for (int n = 0; n < 6; n++) add(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'd1);

      for (int n = 0; n < vecs.size(); n++) begin
         signal = vecs[n].sig;
         clear  = vecs[n].clr;
         tick();
         check($sformatf("v%0d_outedge", n), 32'(outedge), 32'(vecs[n].e_out));
         check($sformatf("v%0d_stable", n), 32'(stable), 32'(vecs[n].e_st));
         check($sformatf("v%0d_pending", n), 32'(pending), 32'(vecs[n].e_pend));
         check($sformatf("v%0d_count", n), 32'(event_count), 32'(vecs[n].e_cnt));
      end
      clear = '0;

      // mode behaviour on ch2: both, fall-only, disabled
      modes[0] = 2'b10; exp_a[0] = 1; exp_b[0] = 1;
      modes[1] = 2'b01; exp_a[1] = 0; exp_b[1] = 1;
      modes[2] = 2'b11; exp_a[2] = 0; exp_b[2] = 0;
      for (int m = 0; m < 3; m++) begin
         base = int'(event_count);
         mode = modes[m];
         signal[2] = 1'b1;
         run_phase(10, 2, a, ra);
         check($sformatf("m%0d_rise_pulses", m), 32'(a), 32'(exp_a[m]));
         check($sformatf("m%0d_stable_hi", m), 32'(stable[2]), 1);
         signal[2] = 1'b0;
         run_phase(12, 2, b, rb);
         check($sformatf("m%0d_fall_pulses", m), 32'(b), 32'(exp_b[m]));
         check($sformatf("m%0d_stable_lo", m), 32'(stable[2]), 0);
         check($sformatf("m%0d_pulse_width", m), 32'((ra > rb) ? ra : rb),
               32'((exp_a[m] + exp_b[m] > 0) ? 1 : 0));
         check($sformatf("m%0d_count_delta", m), 32'(int'(event_count) - base),
               32'(exp_a[m] + exp_b[m]));
      end
      check("count_after_modes", 32'(event_count), 4);

      // reset in the middle of a debounce run, input held high through release
      mode = 2'b00;
      signal = '0;
      repeat (12) tick();
      signal = 4'b1000;
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_outedge", 32'(outedge), 0);
      check("async_rst_stable", 32'(stable), 0);
      check("async_rst_pending", 32'(pending), 0);
      check("async_rst_count", 32'(event_count), 0);
      tick();
      tick();
      reset = 1'b0;
      first_idx = -1;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (outedge[3]) begin
            pulses++;
            if (first_idx < 0) first_idx = c;
         end
      end
      check("por_pulse_cycle", 32'(first_idx), 6);
      check("por_pulse_count", 32'(pulses), 1);
      check("por_stable", 32'(stable), 32'(4'b1000));
      check("por_event_count", 32'(event_count), 1);

      // saturation on the 3-bit counter instance
      for (int p = 0; p < 5; p++) begin
         sig_s = 4'b0001;
         repeat (8) tick();
         sig_s = 4'b0000;
         repeat (8) tick();
      end
      check("sat_preset", 32'(cnt_s), 5);
      sig_s = 4'b1111;
      repeat (10) tick();
      check("sat_all_rise_stable", 32'(st_s), 32'(4'b1111));
      check("sat_all_rise_count", 32'(cnt_s), 7);
      mode_s = 2'b10;
      sig_s = 4'b0000;
      repeat (10) tick();
      check("sat_hold", 32'(cnt_s), 7);
      mode_s = 2'b00;
      sig_s = 4'b0011;
      found = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (out_s != 4'b0000) begin
            found = 1;
            break;
         end
      end
      check("clr_edge_seen", 32'(found), 1);
      check("clr_edge_bits", 32'(out_s), 32'(4'b0011));
      cclr_s = 1'b1;
      tick();
      cclr_s = 1'b0;
      check("clr_with_edges", 32'(cnt_s), 2);
      tick();
      check("clr_after", 32'(cnt_s), 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
